// File: rtl/systolic_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl_pkg
// Shared definitions for the systolic tile sequencer: command op codes,
// cell op codes driven to the processor_AB array, gauss_op constants,
// FSM state encoding and a command decode helper.
// -----------------------------------------------------------------------------
package systolic_seq_ctrl_pkg;

  // Host command op codes (2 bits)
  typedef enum logic [1:0] {
    CMD_MUL_MAT = 2'b00,
    CMD_EVAL    = 2'b01,
    CMD_GAUSS   = 2'b10,
    CMD_ILLEGAL = 2'b11
  } cmd_op_e;

  // Cell op codes
  localparam logic [3:0] OP_NONE    = 4'b0000;
  localparam logic [3:0] OP_MUL_MAT = 4'b1000;
  localparam logic [3:0] OP_EVAL    = 4'b1010;
  localparam logic [3:0] OP_GAUSS   = 4'b1110;

  // gauss_op constants for column-0 cells
  localparam logic [1:0] GOP_PASS = 2'b00;
  localparam logic [1:0] GOP_LOAD = 2'b01;
  localparam logic [1:0] GOP_ADD  = 2'b10;
  localparam logic [1:0] GOP_HOLD = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FEED  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  // Per-command control values held on the west edge for the whole command
  typedef struct packed {
    logic [3:0] op;
    logic [1:0] gop;
    logic       func_a;
  } op_cfg_t;

  // Map a host command op onto the cell control values; illegal maps to all-zero
  function automatic op_cfg_t decode_cmd(input logic [1:0] cmd);
    op_cfg_t cfg;
    case (cmd)
      CMD_MUL_MAT: cfg = '{op: OP_MUL_MAT, gop: GOP_PASS, func_a: 1'b0};
      CMD_EVAL:    cfg = '{op: OP_EVAL,    gop: GOP_HOLD, func_a: 1'b0};
      CMD_GAUSS:   cfg = '{op: OP_GAUSS,   gop: GOP_HOLD, func_a: 1'b1};
      default:     cfg = '{op: OP_NONE,    gop: GOP_PASS, func_a: 1'b0};
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/systolic_seq_ctrl_skew.sv
// -----------------------------------------------------------------------------
// ctrl_skew_line
// Diagonal skew for the west-edge start/finish pair. Tap r presents the
// unskewed pulse r cycles after tap 0; tap 0 is itself a register loaded with
// the value the sequencer wants on row 0 in the next cycle.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear of every tap (squashes in-flight pulses)
//   start_in     next-cycle start for row 0
//   finish_in    next-cycle finish for row 0
//   start_tap    start per row   [DEPTH-1:0]
//   finish_tap   finish per row  [DEPTH-1:0]
// -----------------------------------------------------------------------------
module ctrl_skew_line #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start_in,
  input  logic             finish_in,
  output logic [DEPTH-1:0] start_tap,
  output logic [DEPTH-1:0] finish_tap
);

  // bit 1 = finish, bit 0 = start
  logic [DEPTH-1:0][1:0] tap_q;
  logic [DEPTH-1:0][1:0] tap_d;

  // Shift the pair down one row per cycle, or clear everything
  always_comb begin
    tap_d    = '0;
    tap_d[0] = {finish_in, start_in};
    for (int r = 1; r < DEPTH; r++) begin
      tap_d[r] = tap_q[r-1];
    end
    if (clr) begin
      tap_d = '0;
    end else begin
      tap_d = tap_d;
    end
  end

  // Tap registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_q <= '0;
    end else begin
      tap_q <= tap_d;
    end
  end

  // Split the pair into per-row output vectors
  always_comb begin
    start_tap  = '0;
    finish_tap = '0;
    for (int r = 0; r < DEPTH; r++) begin
      start_tap[r]  = tap_q[r][0];
      finish_tap[r] = tap_q[r][1];
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_seq_ctrl
// Sequencer for one systolic tile of GF processing cells. Accepts one command
// (MUL_MAT, EVAL, GAUSS), streams cmd_len operand addresses, drives skewed
// start/finish per row, waits NUM_ROW+NUM_COL cycles for the tile to drain,
// then pulses done (with err for an illegal op).
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_op, cmd_len, cmd_base    command op, column count, first address
//   abort                        synchronous abort (acts in FEED/DRAIN)
//   rd_en, rd_addr               operand/key memory read
//   start_row, finish_row        skewed per-row control
//   op_out, gauss_op_out, functionA  cell controls held for the command
//   busy, done, err              status
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int NUM_ROW     = 4,
  parameter int NUM_COL     = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int LEN_W       = 8,
  parameter int ADDR_W      = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [LEN_W-1:0]       cmd_len,
  input  logic [ADDR_W-1:0]      cmd_base,
  input  logic                   abort,
  output logic                   rd_en,
  output logic [ADDR_W-1:0]      rd_addr,
  output logic [NUM_ROW-1:0]     start_row,
  output logic [NUM_ROW-1:0]     finish_row,
  output logic [OP_CODE_LEN-1:0] op_out,
  output logic [1:0]             gauss_op_out,
  output logic                   functionA,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int DRAIN_LEN = NUM_ROW + NUM_COL;
  localparam int D_W       = $clog2(DRAIN_LEN + 1);

  state_e            state_q,     state_d;
  logic [LEN_W-1:0]  k_q,         k_d;
  logic [D_W-1:0]    d_q,         d_d;
  logic [LEN_W-1:0]  len_q,       len_d;
  op_cfg_t           cfg_q,       cfg_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rd_en_q,     rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q,   rd_addr_d;
  logic              busy_q,      busy_d;
  logic              done_q,      done_d;
  logic              err_q,       err_d;
  logic              start_nxt;
  logic              finish_nxt;
  logic              skew_clr;

  // Next-state, counters and next values of every registered output
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    d_d        = d_q;
    len_d      = len_q;
    cfg_d      = cfg_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = '0;
    err_d      = 1'b0;
    start_nxt  = 1'b0;
    finish_nxt = 1'b0;
    skew_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          len_d = cmd_len;
          k_d   = '0;
          d_d   = '0;
          if (cmd_op == CMD_ILLEGAL) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
            cfg_d   = '0;
          end else if (cmd_len == LEN_W'(0)) begin
            state_d = ST_DONE;
            cfg_d   = decode_cmd(cmd_op);
          end else begin
            // k==0 is the next cycle, so row 0 start is loaded now
            state_d    = ST_FEED;
            cfg_d      = decode_cmd(cmd_op);
            rd_en_d    = 1'b1;
            rd_addr_d  = cmd_base;
            start_nxt  = 1'b1;
            finish_nxt = (cmd_len == LEN_W'(1));
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FEED: begin
        if (abort) begin
          state_d  = ST_IDLE;
          k_d      = '0;
          d_d      = '0;
          cfg_d    = '0;
          skew_clr = 1'b1;
        end else if (k_q == len_q - LEN_W'(1)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
          d_d     = '0;
        end else begin
          // Look one column ahead so row 0 finish lines up with k==len-1
          k_d        = k_q + LEN_W'(1);
          rd_en_d    = 1'b1;
          rd_addr_d  = rd_addr_q + ADDR_W'(1);
          finish_nxt = ((k_q + LEN_W'(1)) == (len_q - LEN_W'(1)));
        end
      end

      ST_DRAIN: begin
        if (abort) begin
          state_d  = ST_IDLE;
          k_d      = '0;
          d_d      = '0;
          cfg_d    = '0;
          skew_clr = 1'b1;
        end else if (d_q == D_W'(DRAIN_LEN - 1)) begin
          state_d = ST_DONE;
          d_d     = '0;
        end else begin
          d_d = d_q + D_W'(1);
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cfg_d   = '0;
      end

      default: begin
        state_d  = ST_IDLE;
        k_d      = '0;
        d_d      = '0;
        cfg_d    = '0;
        skew_clr = 1'b1;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State, counters, latched command and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      d_q         <= '0;
      len_q       <= '0;
      cfg_q       <= '0;
      cmd_ready_q <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      d_q         <= d_d;
      len_q       <= len_d;
      cfg_q       <= cfg_d;
      cmd_ready_q <= cmd_ready_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  ctrl_skew_line #(
    .DEPTH (NUM_ROW)
  ) u_skew (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (skew_clr),
    .start_in   (start_nxt),
    .finish_in  (finish_nxt),
    .start_tap  (start_row),
    .finish_tap (finish_row)
  );

  assign cmd_ready    = cmd_ready_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign op_out       = OP_CODE_LEN'(cfg_q.op);
  assign gauss_op_out = cfg_q.gop;
  assign functionA    = cfg_q.func_a;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_seq_ctrl
// Directed bench for systolic_seq_ctrl (NUM_ROW = NUM_COL = 4). Cycle n of a
// command is the n-th clock period after the accept cycle; outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_len;
  logic [7:0] cmd_base;
  logic       abort;
  logic       rd_en;
  logic [7:0] rd_addr;
  logic [3:0] start_row;
  logic [3:0] finish_row;
  logic [3:0] op_out;
  logic [1:0] gauss_op_out;
  logic       functionA;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  systolic_seq_ctrl #(
    .NUM_ROW     (4),
    .NUM_COL     (4),
    .OP_CODE_LEN (4),
    .LEN_W       (8),
    .ADDR_W      (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_len      (cmd_len),
    .cmd_base     (cmd_base),
    .abort        (abort),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .start_row    (start_row),
    .finish_row   (finish_row),
    .op_out       (op_out),
    .gauss_op_out (gauss_op_out),
    .functionA    (functionA),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present a command in the cycle before a rising edge; returns just after that (accept) edge
  task automatic accept(input logic [1:0] op, input logic [7:0] len, input logic [7:0] base);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_base  = base;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 8'h00;
    cmd_base  = 8'h00;
  endtask

  // Run one command to completion, checking every cycle up to two past done
  task automatic run_cmd(input string nm, input logic [1:0] op, input logic [7:0] len,
                         input logic [7:0] base, input int feed_len, input int done_cyc,
                         input logic [3:0] e_op, input logic [1:0] e_gop,
                         input logic e_fa, input logic e_err);
    logic [3:0] e_st;
    logic [3:0] e_fi;
    logic [7:0] e_addr;
    logic       act;
    e_addr = base;
    accept(op, len, base);
    for (int c = 1; c <= done_cyc + 2; c++) begin
      @(negedge clk);
      e_st = 4'b0000;
      e_fi = 4'b0000;
      for (int r = 0; r < 4; r++) begin
        if (feed_len > 0 && c == 1 + r)        e_st[r] = 1'b1;
        if (feed_len > 0 && c == feed_len + r) e_fi[r] = 1'b1;
      end
      act = (c <= done_cyc);
      chk($sformatf("%s.rd_en@%0d", nm, c), rd_en, (c <= feed_len));
      if (c <= feed_len) begin
        chk($sformatf("%s.rd_addr@%0d", nm, c), rd_addr, e_addr);
        e_addr = e_addr + 8'd1;
      end
      chk($sformatf("%s.start_row@%0d", nm, c), start_row, e_st);
      chk($sformatf("%s.finish_row@%0d", nm, c), finish_row, e_fi);
      chk($sformatf("%s.done@%0d", nm, c), done, (c == done_cyc));
      chk($sformatf("%s.err@%0d", nm, c), err, (c == done_cyc) ? e_err : 1'b0);
      chk($sformatf("%s.busy@%0d", nm, c), busy, act);
      chk($sformatf("%s.cmd_ready@%0d", nm, c), cmd_ready, !act);
      chk($sformatf("%s.op_out@%0d", nm, c), op_out, act ? e_op : 4'b0000);
      chk($sformatf("%s.gauss_op@%0d", nm, c), gauss_op_out, act ? e_gop : 2'b00);
      chk($sformatf("%s.functionA@%0d", nm, c), functionA, act ? e_fa : 1'b0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 8'h00;
    cmd_base  = 8'h00;
    abort     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.cmd_ready_low", cmd_ready, 1'b0);
    chk("rst.busy", busy, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.cmd_ready", cmd_ready, 1'b1);
    chk("idle.busy", busy, 1'b0);
    chk("idle.start_row", start_row, 4'b0000);
    chk("idle.finish_row", finish_row, 4'b0000);
    chk("idle.op_out", op_out, 4'b0000);
    chk("idle.rd_en", rd_en, 1'b0);
    chk("idle.done", done, 1'b0);

    //       name     op     len    base   feed done op       gop    fA    err
    run_cmd("mulmat", 2'b00, 8'd5, 8'h10, 5, 14, 4'b1000, 2'b00, 1'b0, 1'b0);
    run_cmd("gauss1", 2'b10, 8'd1, 8'h33, 1, 10, 4'b1110, 2'b11, 1'b1, 1'b0);
    run_cmd("illegal", 2'b11, 8'd5, 8'h20, 0, 1, 4'b0000, 2'b00, 1'b0, 1'b1);
    run_cmd("len0",   2'b00, 8'd0, 8'h20, 0, 1, 4'b1000, 2'b00, 1'b0, 1'b0);
    run_cmd("eval3",  2'b01, 8'd3, 8'h80, 3, 12, 4'b1010, 2'b11, 1'b0, 1'b0);
    run_cmd("wrap",   2'b00, 8'd4, 8'hFE, 4, 13, 4'b1000, 2'b00, 1'b0, 1'b0);

    // EVAL len=8, abort while k==3 (cycle 4)
    accept(2'b01, 8'd8, 8'h40);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("abf.rd_en@%0d", c), rd_en, 1'b1);
    end
    chk("abf.rd_addr@4", rd_addr, 8'h43);
    chk("abf.start_row@4", start_row, 4'b1000);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    for (int c = 5; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("abf.rd_en@%0d", c), rd_en, 1'b0);
      chk($sformatf("abf.start_row@%0d", c), start_row, 4'b0000);
      chk($sformatf("abf.finish_row@%0d", c), finish_row, 4'b0000);
      chk($sformatf("abf.done@%0d", c), done, 1'b0);
      chk($sformatf("abf.cmd_ready@%0d", c), cmd_ready, 1'b1);
      chk($sformatf("abf.op_out@%0d", c), op_out, 4'b0000);
    end

    // MUL_MAT len=2, abort in DRAIN squashes finish still in the skew pipe
    accept(2'b00, 8'd2, 8'h00);
    repeat (3) @(negedge clk);
    chk("abd.finish_row@3", finish_row, 4'b0010);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    for (int c = 4; c <= 15; c++) begin
      @(negedge clk);
      chk($sformatf("abd.finish_row@%0d", c), finish_row, 4'b0000);
      chk($sformatf("abd.done@%0d", c), done, 1'b0);
      chk($sformatf("abd.busy@%0d", c), busy, 1'b0);
    end

    // Reset pulsed during DRAIN: asynchronous clear, no done afterwards
    accept(2'b00, 8'd4, 8'hFE);
    repeat (7) @(negedge clk);
    chk("rsd.op_out_before", op_out, 4'b1000);
    rst_n = 1'b0;
    #2;
    chk("rsd.busy", busy, 1'b0);
    chk("rsd.cmd_ready", cmd_ready, 1'b0);
    chk("rsd.op_out", op_out, 4'b0000);
    chk("rsd.rd_en", rd_en, 1'b0);
    chk("rsd.start_row", start_row, 4'b0000);
    chk("rsd.finish_row", finish_row, 4'b0000);
    chk("rsd.done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      chk($sformatf("rsd.done_after@%0d", c), done, 1'b0);
      chk($sformatf("rsd.busy_after@%0d", c), busy, 1'b0);
    end
    chk("rsd.cmd_ready_after", cmd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
